// File: rtl/vedic_mac_8_if.sv
// Operand and result streams of the vedic multiply-accumulate stage.
// master drives operands and consumes results; slave is the MAC.
interface vedic_mac_8_if #(
  parameter int ACC_W = 24
);
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_a;
  logic [7:0]       in_b;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_acc;
  logic [7:0]       out_cnt;
  logic             out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_last,
    output out_ready,
    input  in_ready,
    input  out_valid, out_acc, out_cnt, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_last,
    input  out_ready,
    output in_ready,
    output out_valid, out_acc, out_cnt, out_ovf
  );
endinterface

// File: rtl/vedic_mac_8.sv
// Streaming 8x8 vedic multiply-accumulate: groups of products summed
// through a ripple adder, one result per group.
module vedic_mult_2 (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic [3:0] p
);
  logic c1, c2, cy, hi;

  assign c1   = a[1] & b[0];
  assign c2   = a[0] & b[1];
  assign cy   = c1 & c2;
  assign hi   = a[1] & b[1];
  assign p[0] = a[0] & b[0];
  assign p[1] = c1 ^ c2;
  assign p[2] = hi ^ cy;
  assign p[3] = hi & cy;
endmodule

module vedic_mult_4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);
  logic [3:0] q0, q1, q2, q3;

  vedic_mult_2 u0 (.a(a[1:0]), .b(b[1:0]), .p(q0));
  vedic_mult_2 u1 (.a(a[3:2]), .b(b[1:0]), .p(q1));
  vedic_mult_2 u2 (.a(a[1:0]), .b(b[3:2]), .p(q2));
  vedic_mult_2 u3 (.a(a[3:2]), .b(b[3:2]), .p(q3));

  assign p = {4'b0, q0}
           + {2'b0, q1, 2'b0}
           + {2'b0, q2, 2'b0}
           + {q3, 4'b0};
endmodule

module vedic_mult_8 (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);
  logic [7:0] q0, q1, q2, q3;

  vedic_mult_4 u0 (.a(a[3:0]), .b(b[3:0]), .p(q0));
  vedic_mult_4 u1 (.a(a[7:4]), .b(b[3:0]), .p(q1));
  vedic_mult_4 u2 (.a(a[3:0]), .b(b[7:4]), .p(q2));
  vedic_mult_4 u3 (.a(a[7:4]), .b(b[7:4]), .p(q3));

  assign p = {8'b0, q0}
           + {4'b0, q1, 4'b0}
           + {4'b0, q2, 4'b0}
           + {q3, 8'b0};
endmodule

module rca_24 #(
  parameter int W = 24
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co
);
  logic [W:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < W; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i])
                  | (c[i] & (a[i] ^ b[i]));
  end

  assign co = c[W];
endmodule

module vedic_mac_8 #(
  parameter int ACC_W     = 24,
  parameter int MAX_TERMS = 16
) (
  input  logic          clk,
  input  logic          rst,
  vedic_mac_8_if.slave  bus
);
  localparam logic [7:0] CNT_MAX = 8'(MAX_TERMS - 1);

  logic [7:0]       in_cnt;
  logic             s1_valid;
  logic             s1_last;
  logic [7:0]       s1_a;
  logic [7:0]       s1_b;
  logic             s2_valid;
  logic             s2_last;
  logic [15:0]      s2_p;
  logic [15:0]      prod;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] sum;
  logic [7:0]       acc_cnt;
  logic             ovf;
  logic             carry;
  logic             out_valid;
  logic [ACC_W-1:0] out_acc;
  logic [7:0]       out_cnt;
  logic             out_ovf;
  logic             in_ready;
  logic             accept;
  logic             last_eff;
  logic             close;

  // Hold off input while a group close is in flight so the
  // output register is always free when a last reaches ACC.
  assign in_ready = ~((s1_valid & s1_last)
                    | (s2_valid & s2_last)
                    | (out_valid & ~bus.out_ready));
  assign accept   = bus.in_valid & in_ready;
  assign last_eff = bus.in_last | (in_cnt == CNT_MAX);
  assign close    = s2_valid & s2_last;

  vedic_mult_8 u_mult (
    .a (s1_a),
    .b (s1_b),
    .p (prod)
  );

  rca_24 #(.W(ACC_W)) u_add (
    .a  (acc),
    .b  (ACC_W'(s2_p)),
    .ci (1'b0),
    .s  (sum),
    .co (carry)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      in_cnt   <= '0;
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_a    <= bus.in_a;
        s1_b    <= bus.in_b;
        s1_last <= last_eff;
        in_cnt  <= last_eff ? 8'd0 : in_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
      s2_p     <= '0;
    end else begin
      s2_valid <= s1_valid;
      s2_last  <= s1_valid & s1_last;
      s2_p     <= prod;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      acc_cnt <= '0;
      ovf     <= 1'b0;
    end else if (s2_valid) begin
      if (s2_last) begin
        acc     <= '0;
        acc_cnt <= '0;
        ovf     <= 1'b0;
      end else begin
        acc     <= sum;
        acc_cnt <= acc_cnt + 8'd1;
        ovf     <= ovf | carry;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_acc   <= '0;
      out_cnt   <= '0;
      out_ovf   <= 1'b0;
    end else if (close) begin
      out_valid <= 1'b1;
      out_acc   <= sum;
      out_cnt   <= acc_cnt + 8'd1;
      out_ovf   <= ovf | carry;
    end else if (bus.out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(close && out_valid && !bus.out_ready));
      assert (in_cnt <= CNT_MAX);
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_acc   = out_acc;
  assign bus.out_cnt   = out_cnt;
  assign bus.out_ovf   = out_ovf;
endmodule

// File: tb/tb_vedic_mac_8.sv
// Bench for vedic_mac_8: directed latency/backpressure steps plus
// random streams scored against an arithmetic group model.
module tb_vedic_mac_8;
  localparam int MT = 16;

  typedef struct {
    longint acc;
    int     cnt;
    bit     ovf;
  } res_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  vedic_mac_8_if #(.ACC_W(24)) m0 ();
  vedic_mac_8_if #(.ACC_W(16)) m1 ();

  vedic_mac_8 #(.ACC_W(24), .MAX_TERMS(MT)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (m0)
  );

  vedic_mac_8 #(.ACC_W(16), .MAX_TERMS(MT)) u_d16 (
    .clk (clk),
    .rst (rst),
    .bus (m1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic res_t mk(longint s, int c, int w);
    res_t   r;
    longint m;
    m     = 64'sd1 << w;
    r.acc = s % m;
    r.cnt = c;
    r.ovf = (s >= m);
    return r;
  endfunction

  // Model: a group is the running product sum since the last close.
  longint gs[2];
  int     gc[2];
  res_t   q0[$];
  res_t   q1[$];

  always @(negedge clk) begin
    res_t r;
    if (rst) begin
      gs[0] = 0;
      gc[0] = 0;
      q0.delete();
    end else begin
      if (m0.out_valid && m0.out_ready) begin
        check("sb0_expected", q0.size() != 0, 1);
        if (q0.size() != 0) begin
          r = q0.pop_front();
          check("sb0_acc", m0.out_acc, r.acc);
          check("sb0_cnt", m0.out_cnt, r.cnt);
          check("sb0_ovf", m0.out_ovf, r.ovf);
        end
      end
      if (m0.in_valid && m0.in_ready) begin
        gs[0] += int'(m0.in_a) * int'(m0.in_b);
        gc[0]++;
        if (m0.in_last || gc[0] == MT) begin
          q0.push_back(mk(gs[0], gc[0], 24));
          gs[0] = 0;
          gc[0] = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    res_t r;
    if (rst) begin
      gs[1] = 0;
      gc[1] = 0;
      q1.delete();
    end else begin
      if (m1.out_valid && m1.out_ready) begin
        check("sb1_expected", q1.size() != 0, 1);
        if (q1.size() != 0) begin
          r = q1.pop_front();
          check("sb1_acc", m1.out_acc, r.acc);
          check("sb1_cnt", m1.out_cnt, r.cnt);
          check("sb1_ovf", m1.out_ovf, r.ovf);
        end
      end
      if (m1.in_valid && m1.in_ready) begin
        gs[1] += int'(m1.in_a) * int'(m1.in_b);
        gc[1]++;
        if (m1.in_last || gc[1] == MT) begin
          q1.push_back(mk(gs[1], gc[1], 16));
          gs[1] = 0;
          gc[1] = 0;
        end
      end
    end
  end

  task automatic drive(int k, bit v, logic [7:0] a,
                       logic [7:0] b, bit l);
    if (k == 0) begin
      m0.in_valid = v; m0.in_a = a;
      m0.in_b = b; m0.in_last = l;
    end else begin
      m1.in_valid = v; m1.in_a = a;
      m1.in_b = b; m1.in_last = l;
    end
  endtask

  task automatic set_or(int k, bit v);
    if (k == 0) m0.out_ready = v;
    else        m1.out_ready = v;
  endtask

  function automatic bit rdy(int k);
    return (k == 0) ? m0.in_ready : m1.in_ready;
  endfunction

  // Entered and left at posedge+1; waits (bounded) for acceptance.
  task automatic send(int k, logic [7:0] a, logic [7:0] b,
                      bit l, bit rnd);
    bit ok;
    ok = 1'b0;
    drive(k, 1'b1, a, b, l);
    for (int n = 0; n < 64 && !ok; n++) begin
      @(negedge clk);
      if (rdy(k)) ok = 1'b1;
      else begin
        @(posedge clk); #1;
        if (rnd) set_or(k, $urandom_range(0, 3) != 0);
      end
    end
    check(k == 0 ? "send0_accept" : "send1_accept", ok, 1);
    @(posedge clk); #1;
    drive(k, 1'b0, 8'd0, 8'd0, 1'b0);
    if (rnd) set_or(k, $urandom_range(0, 3) != 0);
  endtask

  task automatic drain();
    set_or(0, 1'b1);
    set_or(1, 1'b1);
    for (int n = 0; n < 40 && (q0.size() != 0 || q1.size() != 0); n++) begin
      @(posedge clk); #1;
    end
    check("drain0_left", q0.size(), 0);
    check("drain1_left", q1.size(), 0);
  endtask

  task automatic rand_run(int k, int beats);
    int idle;
    for (int i = 0; i < beats; i++) begin
      idle = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
      repeat (idle) begin
        @(posedge clk); #1;
        set_or(k, $urandom_range(0, 3) != 0);
      end
      send(k, 8'($urandom), 8'($urandom),
           $urandom_range(0, 4) == 0, 1'b1);
    end
    drain();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    drive(0, 1'b0, 8'd0, 8'd0, 1'b0);
    drive(1, 1'b0, 8'd0, 8'd0, 1'b0);
    set_or(0, 1'b1);
    set_or(1, 1'b1);

    // T1: reset with random inputs
    repeat (3) begin
      @(posedge clk); #1;
      drive(0, 1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
      drive(1, 1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
      set_or(0, 1'($urandom));
      set_or(1, 1'($urandom));
    end
    @(posedge clk); #1;
    rst = 1'b0;
    drive(0, 1'b0, 8'd0, 8'd0, 1'b0);
    drive(1, 1'b0, 8'd0, 8'd0, 1'b0);
    set_or(0, 1'b1);
    set_or(1, 1'b1);
    @(negedge clk);
    check("rst_in_ready0", m0.in_ready, 1);
    check("rst_out_valid0", m0.out_valid, 0);
    check("rst_out_acc0", m0.out_acc, 0);
    check("rst_out_cnt0", m0.out_cnt, 0);
    check("rst_out_ovf0", m0.out_ovf, 0);
    check("rst_in_ready1", m1.in_ready, 1);
    check("rst_out_valid1", m1.out_valid, 0);
    check("rst_out_acc1", m1.out_acc, 0);
    @(posedge clk); #1;

    // T2: single beat, result exactly three cycles later
    send(0, 8'd3, 8'd5, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t2_out_valid", m0.out_valid, i == 2);
      if (i == 2) begin
        check("t2_acc", m0.out_acc, 15);
        check("t2_cnt", m0.out_cnt, 1);
        check("t2_ovf", m0.out_ovf, 0);
      end
    end
    @(posedge clk); #1;

    // T3: four max products, two bubbles after last
    repeat (3) send(0, 8'd255, 8'd255, 1'b0, 1'b0);
    send(0, 8'd255, 8'd255, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t3_in_ready", m0.in_ready, i == 2);
      if (i == 2) begin
        check("t3_acc", m0.out_acc, 260100);
        check("t3_cnt", m0.out_cnt, 4);
        check("t3_ovf", m0.out_ovf, 0);
      end
    end
    @(posedge clk); #1;
    drain();

    // T4: backpressure holds the result and blocks input
    set_or(0, 1'b0);
    send(0, 8'd2, 8'd2, 1'b1, 1'b0);
    drive(0, 1'b1, 8'd3, 8'd3, 1'b0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("t4_in_ready", m0.in_ready, 0);
      if (i >= 2) begin
        check("t4_hold_valid", m0.out_valid, 1);
        check("t4_hold_acc", m0.out_acc, 4);
      end
    end
    @(posedge clk); #1;
    set_or(0, 1'b1);
    send(0, 8'd3, 8'd3, 1'b0, 1'b0);
    send(0, 8'd7, 8'd1, 1'b1, 1'b0);
    drain();

    // T5: forced close at MAX_TERMS
    for (int i = 0; i < 20; i++) send(0, 8'd1, 8'd1, i == 19, 1'b0);
    drain();

    // T6a: narrow accumulator wraps and flags, flag clears next group
    send(1, 8'd255, 8'd255, 1'b0, 1'b0);
    send(1, 8'd255, 8'd255, 1'b1, 1'b0);
    send(1, 8'd1, 8'd1, 1'b1, 1'b0);
    drain();

    // T6b: reset discards a partial group
    send(0, 8'd9, 8'd9, 1'b0, 1'b0);
    send(0, 8'd9, 8'd9, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    send(0, 8'd2, 8'd2, 1'b1, 1'b0);
    drain();

    // Random streams with random backpressure on both widths
    rand_run(0, 150);
    rand_run(1, 150);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
